mult_mac_pipe: RTL

Parametrised, pipelined multiply/multiply-accumulate unit with a valid handshake, per-operation signedness and a sticky overflow flag. It generalises the fixed 18x18 signed DSP multiply to arbitrary operand widths, configurable pipeline depth and an optional accumulate mode. It sits in the datapath wherever the core needs multiply or MAC results, for example in the MUL/MAC execution slot and in filter loops. Synthesis maps the product stages onto DSP tiles.

---
 rtl/mult_mac_pipe_if.sv | 28 ++
 rtl/mult_mac_pipe.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mult_mac_pipe_if.sv
// Operand/result bundle for mult_mac_pipe: issue side (master) drives operands,
// the multiplier (slave) returns the registered accumulator and flags.
interface mult_mac_pipe_if #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int ACC_W = 48
);
  logic             en;
  logic             in_valid;
  logic             signed_a;
  logic             signed_b;
  logic             acc;
  logic [A_W-1:0]   A;
  logic [B_W-1:0]   B;
  logic             out_valid;
  logic [ACC_W-1:0] O;
  logic             ovf;

  modport master (
    output en, in_valid, signed_a, signed_b, acc, A, B,
    input  out_valid, O, ovf
  );

  modport slave (
    input  en, in_valid, signed_a, signed_b, acc, A, B,
    output out_valid, O, ovf
  );
endinterface

// File: rtl/mult_mac_pipe.sv
// Pipelined multiply / multiply-accumulate with per-operand signedness and a sticky
// overflow flag. Operands are registered, then pass STAGES product registers before the accumulator.
module mult_mac_pipe #(
  parameter int A_W    = 18,
  parameter int B_W    = 18,
  parameter int STAGES = 2,
  parameter int ACC_W  = 48
) (
  input  logic          clk,
  input  logic          rst,
  mult_mac_pipe_if.slave bus
);
  localparam int P_W = A_W + B_W + 2;

  logic                    in_vld_r;
  logic                    in_acc_r;
  logic                    in_sa_r;
  logic                    in_sb_r;
  logic [A_W-1:0]          in_a_r;
  logic [B_W-1:0]          in_b_r;

  logic signed [A_W:0]     a_ext_s;
  logic signed [B_W:0]     b_ext_s;
  logic signed [P_W-1:0]   prod_full_s;
  logic [ACC_W-1:0]        prod_s;

  logic [STAGES-1:0]       vld_r;
  logic [STAGES-1:0]       acc_r;
  logic [STAGES-1:0]       ps_r;
  logic [ACC_W-1:0]        prod_r [STAGES];

  logic [ACC_W:0]          sum_s;
  logic                    ovf_hit_s;
  logic                    out_valid_r;
  logic [ACC_W-1:0]        o_r;
  logic                    ovf_r;

  // Operand capture register (maps onto the DSP input registers)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vld_r <= 1'b0;
      in_acc_r <= 1'b0;
      in_sa_r  <= 1'b0;
      in_sb_r  <= 1'b0;
      in_a_r   <= '0;
      in_b_r   <= '0;
    end else if (bus.en) begin
      in_vld_r <= bus.in_valid;
      in_acc_r <= bus.acc;
      in_sa_r  <= bus.signed_a;
      in_sb_r  <= bus.signed_b;
      in_a_r   <= bus.A;
      in_b_r   <= bus.B;
    end
  end

  // One extra bit per operand lets a single signed multiply cover every signedness mix
  always_comb begin
    a_ext_s     = {in_sa_r & in_a_r[A_W-1], in_a_r};
    b_ext_s     = {in_sb_r & in_b_r[B_W-1], in_b_r};
    prod_full_s = P_W'(a_ext_s) * P_W'(b_ext_s);
    prod_s      = ACC_W'(prod_full_s);
  end

  // Product pipe carrying {valid, acc, ps, product}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
      acc_r <= '0;
      ps_r  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        prod_r[i] <= '0;
      end
    end else if (bus.en) begin
      vld_r[0]  <= in_vld_r;
      acc_r[0]  <= in_acc_r;
      ps_r[0]   <= in_sa_r | in_sb_r;
      prod_r[0] <= prod_s;
      for (int i = 1; i < STAGES; i++) begin
        vld_r[i]  <= vld_r[i-1];
        acc_r[i]  <= acc_r[i-1];
        ps_r[i]   <= ps_r[i-1];
        prod_r[i] <= prod_r[i-1];
      end
    end
  end

  // Accumulate adder and overflow detection (signed: sign flip, unsigned: carry-out)
  always_comb begin
    sum_s = {1'b0, o_r} + {1'b0, prod_r[STAGES-1]};
    if (ps_r[STAGES-1]) begin
      ovf_hit_s = (o_r[ACC_W-1] == prod_r[STAGES-1][ACC_W-1]) &&
                  (sum_s[ACC_W-1] != o_r[ACC_W-1]);
    end else begin
      ovf_hit_s = sum_s[ACC_W];
    end
  end

  // Accumulator stage: load or accumulate on valid, hold on bubble or stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      o_r         <= '0;
      ovf_r       <= 1'b0;
    end else if (bus.en) begin
      out_valid_r <= vld_r[STAGES-1];
      if (vld_r[STAGES-1]) begin
        if (acc_r[STAGES-1]) begin
          o_r   <= sum_s[ACC_W-1:0];
          ovf_r <= ovf_r | ovf_hit_s;
        end else begin
          o_r   <= prod_r[STAGES-1];
          ovf_r <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.O         = o_r;
  assign bus.ovf       = ovf_r;
endmodule
